// File: rtl/gal16v8_pkg.sv
// Shared constants and types for the GAL16V8 binary JEDEC image writer.
package gal16v8_pkg;

  localparam int GAL16V8_NUM_FUSES = 2194;
  localparam int GAL16V8_JED_BYTES = 279;
  localparam int GAL16V8_HDR_BYTES = 4;
  localparam int SYN_FUSE          = 2192;
  localparam int AC0_FUSE          = 2193;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  // Number of bytes needed to carry n fuses, one fuse per bit.
  function automatic int fuse_bytes(input int n);
    return (n + 7) / 8;
  endfunction

endpackage

// File: rtl/gal16v8_jed_writer_if.sv
// Byte-stream valid/ready link from the JEDEC writer to its file/UART sink.
interface gal16v8_jed_writer_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/gal_jed_checksum.sv
// 16-bit wrapping byte accumulator for the fuse section of the JEDEC image.
module gal_jed_checksum (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        add_en,
  input  logic [7:0]  data,
  output logic [15:0] sum
);

  // Accumulate zero-extended bytes; clear takes priority over add.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= 16'h0000;
    end else if (clear) begin
      sum <= 16'h0000;
    end else if (add_en) begin
      sum <= sum + {8'h00, data};
    end
  end

endmodule

// File: rtl/gal16v8_jed_writer.sv
// Serialises a shadowed GAL16V8 fuse map into a 4-byte header plus fuse bytes,
// streamed over a valid/ready link, with a running fuse-byte checksum.
module gal16v8_jed_writer
  import gal16v8_pkg::*;
#(
  parameter int         NUM_FUSES = GAL16V8_NUM_FUSES,
  parameter logic [7:0] HDR0      = 8'h47,
  parameter logic [7:0] HDR1      = 8'h16,
  parameter logic [7:0] HDR2      = 8'h08,
  parameter logic [7:0] HDR3      = 8'h01
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_FUSES-1:0] fuses,
  gal16v8_jed_writer_if.master out_if,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          checksum,
  output logic                 csum_vld
);

  localparam int         FUSE_BYTES   = fuse_bytes(NUM_FUSES);
  localparam int         PAD_BITS     = FUSE_BYTES * 8;
  localparam logic [8:0] LAST_IDX     = 9'(GAL16V8_HDR_BYTES + FUSE_BYTES - 1);
  localparam logic [8:0] LAST_HDR_IDX = 9'(GAL16V8_HDR_BYTES - 1);

  state_t                 state_r;
  logic [8:0]             byte_idx_r;
  logic [NUM_FUSES-1:0]   shadow_r;
  logic [PAD_BITS-1:0]    padded_s;
  logic [8:0]             next_idx_s;
  logic [8:0]             fuse_byte_s;
  logic [7:0]             next_byte_s;
  logic                   xfer_s;
  logic                   accept_s;
  logic                   add_en_s;

  // Zero padding keeps the last fuse byte's upper bits in range and reading 0.
  assign padded_s = {{(PAD_BITS - NUM_FUSES){1'b0}}, shadow_r};

  assign xfer_s   = out_if.out_valid && out_if.out_ready;
  assign accept_s = (state_r == IDLE) && start && !abort;
  assign add_en_s = xfer_s && (state_r == DATA) && !abort;

  // Select the byte that follows the one currently presented.
  always_comb begin
    next_idx_s  = byte_idx_r + 9'd1;
    fuse_byte_s = next_idx_s - 9'(GAL16V8_HDR_BYTES);
    if (next_idx_s < 9'(GAL16V8_HDR_BYTES)) begin
      case (next_idx_s[1:0])
        2'd0:    next_byte_s = HDR0;
        2'd1:    next_byte_s = HDR1;
        2'd2:    next_byte_s = HDR2;
        default: next_byte_s = HDR3;
      endcase
    end else if (fuse_byte_s < 9'(FUSE_BYTES)) begin
      next_byte_s = padded_s[{fuse_byte_s, 3'b000} +: 8];
    end else begin
      next_byte_s = 8'h00;
    end
  end

  // Transfer FSM with registered stream and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r          <= IDLE;
      byte_idx_r       <= 9'd0;
      shadow_r         <= '0;
      out_if.out_data  <= 8'h00;
      out_if.out_valid <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      csum_vld         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            shadow_r         <= fuses;
            state_r          <= HDR;
            byte_idx_r       <= 9'd0;
            out_if.out_data  <= HDR0;
            out_if.out_valid <= 1'b1;
            busy             <= 1'b1;
            csum_vld         <= 1'b0;
          end
        end
        HDR, DATA: begin
          if (abort) begin
            state_r          <= IDLE;
            byte_idx_r       <= 9'd0;
            out_if.out_valid <= 1'b0;
            busy             <= 1'b0;
          end else if (xfer_s) begin
            if (byte_idx_r == LAST_IDX) begin
              state_r          <= IDLE;
              byte_idx_r       <= 9'd0;
              out_if.out_valid <= 1'b0;
              busy             <= 1'b0;
              done             <= 1'b1;
              csum_vld         <= 1'b1;
            end else begin
              byte_idx_r      <= next_idx_s;
              out_if.out_data <= next_byte_s;
              if (byte_idx_r == LAST_HDR_IDX) begin
                state_r <= DATA;
              end
            end
          end
        end
        default: begin
          state_r          <= IDLE;
          byte_idx_r       <= 9'd0;
          out_if.out_valid <= 1'b0;
          busy             <= 1'b0;
        end
      endcase
    end
  end

  gal_jed_checksum u_checksum (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept_s),
    .add_en (add_en_s),
    .data   (out_if.out_data),
    .sum    (checksum)
  );

endmodule

// File: tb/tb_gal16v8_jed_writer.sv
// Directed, table-driven bench for the GAL16V8 JEDEC image writer.
module tb_gal16v8_jed_writer;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [2193:0] fuses;
  logic          busy;
  logic          done;
  logic [15:0]   checksum;
  logic          csum_vld;

  gal16v8_jed_writer_if out_if ();

  gal16v8_jed_writer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .fuses    (fuses),
    .out_if   (out_if.master),
    .busy     (busy),
    .done     (done),
    .checksum (checksum),
    .csum_vld (csum_vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2193:0] f;
    int            idx;
    logic [7:0]    exp_byte;
    logic [15:0]   exp_csum;
    int            mode;   // 0: ready=1, 1: backpressure, 2: start while busy
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] got[279];
  int         n_got, first_xfer, last_xfer, done_cyc, done_cnt, stall_bad;
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Independent reference: byte k of the image from the fuse map.
  function automatic logic [7:0] model_byte(input logic [2193:0] f, input int k);
    logic [7:0] b;
    int         bit_i;
    case (k)
      0: b = 8'h47;
      1: b = 8'h16;
      2: b = 8'h08;
      3: b = 8'h01;
      default: begin
        for (int j = 0; j < 8; j++) begin
          bit_i = 8 * (k - 4) + j;
          b[j]  = (bit_i < 2194) ? f[bit_i] : 1'b0;
        end
      end
    endcase
    return b;
  endfunction

  function automatic logic [15:0] model_csum(input logic [2193:0] f);
    logic [15:0] s = 16'h0000;
    for (int k = 4; k < 279; k++) s = s + {8'h00, model_byte(f, k)};
    return s;
  endfunction

  task automatic do_start(input logic [2193:0] f);
    fuses = f;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_latency", {busy, out_if.out_valid, out_if.out_data}, {1'b1, 1'b1, 8'h47});
  endtask

  // Acts at each falling edge: sample outputs, then drive ready for the next edge.
  task automatic run_stream(input int mode, input int stop_at, input logic [2193:0] alt);
    int         stall_left = 3;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       rdy;
    bit         hit = 1'b0;
    n_got = 0; first_xfer = -1; last_xfer = -1; done_cyc = -1; done_cnt = 0; stall_bad = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (prev_stall && out_if.out_data !== prev_data) stall_bad++;
      if (done_cyc >= 0 || n_got == stop_at) break;
      if (mode == 1 && n_got == 10 && stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end else if (mode == 1 && n_got != 10) begin
        rdy = ($urandom_range(0, 3) != 0);
      end else begin
        rdy = 1'b1;
      end
      if (mode == 2 && n_got == 50 && !hit) begin
        start = 1'b1;
        fuses = alt;
        hit   = 1'b1;
      end else begin
        start = 1'b0;
      end
      out_if.out_ready = rdy;
      prev_stall = out_if.out_valid && !rdy;
      prev_data  = out_if.out_data;
      if (out_if.out_valid && rdy) begin
        if (n_got < 279) got[n_got] = out_if.out_data;
        if (first_xfer < 0) first_xfer = cyc;
        last_xfer = cyc;
        n_got++;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_stream(input logic [2193:0] f, input int mode);
    int bad = 0;
    for (int k = 0; k < 279; k++) if (got[k] !== model_byte(f, k)) bad++;
    chk("transfer_count", n_got, 279);
    chk("byte_mismatches", bad, 0);
    chk("done_latency", done_cyc - last_xfer, 1);
    chk("csum_vld", csum_vld, 1'b1);
    chk("csum_model", checksum, model_csum(f));
    if (mode == 0) chk("burst_length", last_xfer - first_xfer, 278);
    if (mode == 1) chk("stall_stable", stall_bad, 0);
    @(negedge clk);
    chk("done_pulse_end", {done, busy, out_if.out_valid, csum_vld}, 4'b0001);
  endtask

  initial begin
    logic [2193:0] f;
    int            dseen;

    rst = 1'b1; start = 1'b0; abort = 1'b0; fuses = '0; out_if.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", {out_if.out_valid, busy, done, csum_vld, out_if.out_data, checksum},
        28'h0000000);
    rst = 1'b0;
    @(negedge clk);

    f = '0;       vecs[0] = '{f, 4,   8'h00, 16'h0000, 0};
    f = '1;       vecs[1] = '{f, 278, 8'h03, 16'h10F1, 0};
    f = '0; f[9] = 1'b1;
                  vecs[2] = '{f, 5,   8'h02, 16'h0002, 0};
    f = '0; f[2193] = 1'b1;
                  vecs[3] = '{f, 278, 8'h02, 16'h0002, 0};
    f = '1;       vecs[4] = '{f, 277, 8'hFF, 16'h10F1, 1};
    f = '0; f[0] = 1'b1;
                  vecs[5] = '{f, 4,   8'h01, 16'h0001, 2};

    for (int i = 0; i < 6; i++) begin
      do_start(vecs[i].f);
      run_stream(vecs[i].mode, -1, ~vecs[i].f);
      chk($sformatf("v%0d_byte%0d", i, vecs[i].idx), got[vecs[i].idx], vecs[i].exp_byte);
      chk($sformatf("v%0d_csum", i), checksum, vecs[i].exp_csum);
      chk($sformatf("v%0d_done_cnt", i), done_cnt, 1);
      check_stream(vecs[i].f, vecs[i].mode);
    end

    // Abort at byte 100 with a same-cycle transfer pending.
    do_start(vecs[1].f);
    run_stream(0, 100, '0);
    chk("abort_reached", n_got, 100);
    abort = 1'b1;
    out_if.out_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_next", {out_if.out_valid, busy}, 2'b00);
    dseen = 0;
    for (int c = 0; c < 5; c++) begin
      if (done) dseen++;
      @(negedge clk);
    end
    chk("abort_no_done", dseen, 0);
    chk("abort_csum_vld", csum_vld, 1'b0);

    // Start and abort together in IDLE: abort wins.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", {out_if.out_valid, busy}, 2'b00);

    // Reset mid-stream at byte 200, then a fresh full image.
    do_start(vecs[1].f);
    run_stream(0, 200, '0);
    chk("rst_reached", n_got, 200);
    rst = 1'b1;
    #1;
    chk("rst_midstream", {out_if.out_valid, busy, done, csum_vld, out_if.out_data, checksum},
        28'h0000000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start(vecs[2].f);
    run_stream(0, -1, '0);
    chk("post_rst_csum", checksum, 16'h0002);
    check_stream(vecs[2].f, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
